// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cacheline memory-port arbiter: FSM states and requester ids.
package arb_types;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_RD    = 3'd1,
    D_RD    = 3'd2,
    D_WR    = 3'd3,
    RECOVER = 3'd4
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_src_t;

endpackage

// File: rtl/cache_arbiter_rr_pick.sv
// Combinational winner select between icache and dcache line requests.
// grant_src encodes arb_src_t (0 = icache, 1 = dcache).
module arb_rr_pick
  import arb_types::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_src
);

  always_comb begin
    grant_vld = i_req | d_req;
    grant_src = DCACHE;
    if (i_req && !d_req)
      grant_src = ICACHE;
    // On a tie, round-robin hands the port to whoever did not have it last.
    else if (i_req && d_req && RR_EN && (last_grant == DCACHE))
      grant_src = ICACHE;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Serialises icache line reads and dcache reads/writebacks onto one cacheline
// adaptor port; one transaction at a time, with a one-cycle recover gap after each.
module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q, state_d;
  arb_src_t          last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              grant_vld, grant_src, grant_take;

  arb_rr_pick #(.RR_EN(RR_EN)) u_pick (
    .i_req      (i_mem_read),
    .d_req      (d_mem_read | d_mem_write),
    .last_grant (last_grant_q),
    .grant_vld  (grant_vld),
    .grant_src  (grant_src)
  );

  assign grant_take = (state_q == IDLE) && grant_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request copies are frozen at the grant edge so cache-side changes mid-burst are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= ICACHE;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (grant_take) begin
      last_grant_q <= arb_src_t'(grant_src);
      addr_q       <= (grant_src == DCACHE) ? d_mem_address : i_mem_address;
      if ((grant_src == DCACHE) && d_mem_write)
        wdata_q <= d_mem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (grant_vld) begin
          if (grant_src == ICACHE) state_d = I_RD;
          else if (d_mem_write)    state_d = D_WR;  // read+write together resolves to write
          else                     state_d = D_RD;
        end
      I_RD, D_RD, D_WR:
        if (pmem_resp) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_mem_resp = 1'b0;
    d_mem_resp = 1'b0;
    case (state_q)
      I_RD: begin pmem_read  = 1'b1; i_mem_resp = pmem_resp; end
      D_RD: begin pmem_read  = 1'b1; d_mem_resp = pmem_resp; end
      D_WR: begin pmem_write = 1'b1; d_mem_resp = pmem_resp; end
      default: ;
    endcase
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_mem_rdata  = pmem_rdata;
  assign d_mem_rdata  = pmem_rdata;

`ifndef SYNTHESIS
  a_d_rw_excl: assert property (@(posedge clk) disable iff (reset) !(d_mem_read && d_mem_write))
    else $error("cache_arbiter: d_mem_read and d_mem_write high together");
`endif

endmodule
